// File: rtl/mealy_seq_detector_if.sv
// Serial stream, pattern-load and status bundle for mealy_seq_detector.
// The detector binds to the slave modport; the driving side uses master.
interface mealy_seq_detector_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned SW = $clog2(PAT_LEN);

  logic               inp;
  logic               in_valid;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               outp;
  logic [SW-1:0]      state;
  logic [PAT_LEN-1:0] history;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output inp, in_valid, pat_load, pat_in,
    input  outp, state, history, match_cnt
  );

  modport slave (
    input  inp, in_valid, pat_load, pat_in,
    output outp, state, history, match_cnt
  );
endinterface

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with a runtime-loadable pattern, overlap or
// non-overlap matching, KMP-style fallback and a saturating match counter.
module mealy_seq_detector #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned        OVERLAP = 1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mealy_seq_detector_if.slave  bus
);
  localparam int unsigned SW = $clog2(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [SW-1:0]      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               match;
  logic [PAT_LEN-1:0] win;
  logic [PAT_LEN-1:0] mask;
  logic               hit;
  int unsigned        lim;
  logic [SW-1:0]      fall;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output logic: match flag is purely combinational on the completing bit
  always_comb begin
    accept = bus.in_valid & ~bus.pat_load & ~rst;
    match  = accept & (state_q == SW'(PAT_LEN - 1)) & (bus.inp == pat_q[0]);
  end

  // Fallback: longest k <= lim whose last k window bits equal the pattern's
  // first k bits. Bounding k by state+1 keeps bits from before a reset or
  // pattern load out of the search; on a match the bound is the border length.
  always_comb begin
    win  = {hist_q[PAT_LEN-2:0], bus.inp};
    fall = '0;
    mask = '0;
    hit  = 1'b0;
    if (match) begin
      lim = (OVERLAP != 0) ? PAT_LEN - 1 : 0;
    end else begin
      lim = 32'(state_q) + 1;
      if (lim > PAT_LEN - 1) lim = PAT_LEN - 1;
    end
    for (int unsigned k = 1; k < PAT_LEN; k++) begin
      mask = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
      hit  = (((win ^ (pat_q >> (PAT_LEN - k))) & mask) == '0) && (k <= lim);
      if (hit) fall = SW'(k);
    end
  end

  // Next-state logic: pat_load outranks in_valid; rst is applied in the register
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      state_d = '0;
    end else if (bus.in_valid) begin
      hist_d  = win;
      state_d = fall;
      if (match && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.outp      = match;
  assign bus.state     = state_q;
  assign bus.history   = hist_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench: three detector variants (overlap, non-overlap, 2-bit
// counter) share one stimulus stream and are checked against a bit-level model.
module tb_mealy_seq_detector;
  logic       clk = 1'b0;
  logic       rst, inp, in_valid, pat_load;
  logic [3:0] pat_in;

  always #5 clk = ~clk;

  mealy_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
  mealy_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
  mealy_seq_detector_if #(.PAT_LEN(4), .CNT_W(2)) if_c ();

  assign if_a.inp = inp;  assign if_a.in_valid = in_valid;
  assign if_a.pat_load = pat_load;  assign if_a.pat_in = pat_in;
  assign if_b.inp = inp;  assign if_b.in_valid = in_valid;
  assign if_b.pat_load = pat_load;  assign if_b.pat_in = pat_in;
  assign if_c.inp = inp;  assign if_c.in_valid = in_valid;
  assign if_c.pat_load = pat_load;  assign if_c.pat_in = pat_in;

  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct packed {
    bit [2:0]      outp;
    bit [2:0][1:0] st;
    bit [2:0][3:0] hist;
    bit [2:0][7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [2:0] obs_outp;

  logic [3:0] m_pat[3];
  logic [3:0] m_hist[3];
  int         m_seen[3];
  int         m_cnt[3];
  int         m_max[3] = '{255, 255, 3};
  bit         m_ovl[3] = '{1'b1, 1'b0, 1'b1};
  string      nm[3]    = '{"A", "B", "C"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Longest k<4 with k <= bits seen since restart and the last k bits equal the pattern prefix
  function automatic int exp_state(input logic [3:0] p, input logic [3:0] h, input int seen);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < 4; k++) begin
      ok = (k <= seen);
      for (int j = 0; j < k; j++)
        if (h[j] !== p[4-k+j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic step(input bit r, input bit ld, input bit [3:0] pin, input bit v, input bit b);
    exp_t       e;
    bit         acc, o;
    logic [1:0] o_st[3];
    logic [3:0] o_hist[3];
    logic [7:0] o_cnt[3];
    @(negedge clk);
    rst = r; pat_load = ld; pat_in = pin; in_valid = v; inp = b;
    acc = v && !ld && !r;
    for (int c = 0; c < 3; c++) begin
      o = acc && (m_seen[c] >= 3) && ({m_hist[c][2:0], b} == m_pat[c]);
      e.outp[c] = o;
      if (r) begin
        m_pat[c] = 4'b1011; m_hist[c] = '0; m_seen[c] = 0; m_cnt[c] = 0;
      end else if (ld) begin
        m_pat[c] = pin; m_hist[c] = '0; m_seen[c] = 0;
      end else if (v) begin
        m_hist[c] = {m_hist[c][2:0], b};
        if (o && !m_ovl[c]) m_seen[c] = 0;
        else if (m_seen[c] < 16) m_seen[c]++;
        if (o && m_cnt[c] < m_max[c]) m_cnt[c]++;
      end
      e.st[c]   = 2'(exp_state(m_pat[c], m_hist[c], m_seen[c]));
      e.hist[c] = m_hist[c];
      e.cnt[c]  = 8'(m_cnt[c]);
    end
    sb.push_back(e);
    #1;
    obs_outp = {if_c.outp, if_b.outp, if_a.outp};
    @(posedge clk);
    #1;
    cyc++;
    o_st[0] = if_a.state;   o_st[1] = if_b.state;   o_st[2] = if_c.state;
    o_hist[0] = if_a.history; o_hist[1] = if_b.history; o_hist[2] = if_c.history;
    o_cnt[0] = if_a.match_cnt; o_cnt[1] = if_b.match_cnt; o_cnt[2] = {6'd0, if_c.match_cnt};
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s.outp", nm[c]), 32'(obs_outp[c]), 32'(e.outp[c]));
      check($sformatf("%s.state", nm[c]), 32'(o_st[c]), 32'(e.st[c]));
      check($sformatf("%s.history", nm[c]), 32'(o_hist[c]), 32'(e.hist[c]));
      check($sformatf("%s.cnt", nm[c]), 32'(o_cnt[c]), 32'(e.cnt[c]));
    end
  endtask

  task automatic feed(input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 4'h0, 1'b1, bits[i]);
  endtask

  initial begin
    rst = 1'b1; inp = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = '0;
    for (int c = 0; c < 3; c++) begin
      m_pat[c] = 4'b1011; m_hist[c] = '0; m_seen[c] = 0; m_cnt[c] = 0;
    end
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
    check("rst.state", 32'(if_a.state), 0);
    check("rst.cnt", 32'(if_a.match_cnt), 0);

    // 1,0,1,1,0,1,1: overlap hits twice, non-overlap once
    feed(16'b1011011, 7);
    check("ovl.cnt", 32'(if_a.match_cnt), 2);
    check("ovl.state", 32'(if_a.state), 1);
    check("ovl.hist", 32'(if_a.history), 32'b1011);
    check("novl.cnt", 32'(if_b.match_cnt), 1);

    // gap with in_valid low and inp toggling
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    feed(16'b101, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 1'b0, i[0]);
    check("gap.state", 32'(if_a.state), 3);
    feed(16'b1, 1);
    check("gap.cnt", 32'(if_a.match_cnt), 1);

    // mid-sequence reset, with a would-be completing bit during reset
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    feed(16'b101, 3);
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    feed(16'b1, 1);
    check("rstmid.state", 32'(if_a.state), 1);
    check("rstmid.cnt", 32'(if_a.match_cnt), 0);

    // pattern load in state 3 with a completing bit present is ignored
    feed(16'b01, 2);
    step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    check("load.state", 32'(if_a.state), 0);
    feed(16'b1111111, 7);
    check("p1111.cnt", 32'(if_a.match_cnt), 4);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    feed(16'b1011, 4);
    check("p1111.nomatch", 32'(if_a.match_cnt), 4);

    // KMP fallback with a non-trivial border
    step(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0);
    feed(16'b1001001, 7);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
    feed(16'b000100010, 9);

    // counter saturation with five overlapping matches
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    feed(16'b1011011011011011, 16);
    check("sat.cnt", 32'(if_c.match_cnt), 3);
    check("sat.full", 32'(if_a.match_cnt), 5);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 60) == 0, $urandom_range(0, 20) == 0,
           4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
